// File: rtl/icache_param.sv
// Parametrised direct-mapped instruction cache with a burst-refill FSM and a single-cycle flush.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_param #(
  parameter int SETS      = 16,
  parameter int BLK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 0;
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int TAG_W = 30 - IDX_W - OFF_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_WORDS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t             state_r, state_next_s;
  logic [TAG_W-1:0]   mtag_r;
  logic [IDX_W-1:0]   midx_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [SETS-1:0]    valid_r;
  logic [TAG_W-1:0]   tag_r  [SETS];
  logic [31:0]        data_r [SETS][BLK_WORDS];

  logic [TAG_W-1:0]   req_tag_s;
  logic [IDX_W-1:0]   req_idx_s;
  logic [CNT_W-1:0]   req_off_s;
  logic               hit_s;
  logic               start_fill_s;
  logic               beat_s;
  logic               last_beat_s;
  logic [29:0]        word_addr_s;

  assign req_tag_s = imemaddr[31 -: TAG_W];
  assign req_idx_s = imemaddr[2 + OFF_W +: IDX_W];

  generate
    if (OFF_W > 0) begin : g_off
      assign req_off_s = imemaddr[2 +: OFF_W];
    end else begin : g_no_off
      assign req_off_s = 1'b0;
    end
  endgenerate

  // Flush forces a miss in its own cycle so a stale line is never returned.
  assign hit_s        = (state_r == IDLE) & imemREN & ~iflush & valid_r[req_idx_s]
                        & (tag_r[req_idx_s] == req_tag_s);
  assign start_fill_s = (state_r == IDLE) & imemREN & ~hit_s & ~iflush;
  assign beat_s       = (state_r == FILL) & ~iwait;
  assign last_beat_s  = beat_s & (cnt_r == LAST_CNT);
  assign word_addr_s  = (30'({mtag_r, midx_r}) << OFF_W) | 30'(cnt_r);

  // Hit path and memory request outputs
  always_comb begin
    ihit     = hit_s;
    imemload = 32'h0000_0000;
    iREN     = 1'b0;
    iaddr    = 32'h0000_0000;
    if (hit_s) begin
      imemload = data_r[req_idx_s][req_off_s];
    end else begin
      imemload = 32'h0000_0000;
    end
    if (state_r == FILL) begin
      iREN  = 1'b1;
      iaddr = {word_addr_s, 2'b00};
    end else begin
      iREN  = 1'b0;
      iaddr = 32'h0000_0000;
    end
  end

  // Next-state logic; a flush aborts a fill even on its last beat
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_fill_s) state_next_s = FILL;
        else              state_next_s = IDLE;
      end
      FILL: begin
        if (iflush || last_beat_s) state_next_s = IDLE;
        else                       state_next_s = FILL;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, latched miss address and beat counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      mtag_r  <= '0;
      midx_r  <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      if (start_fill_s) begin
        mtag_r <= req_tag_s;
        midx_r <= req_idx_s;
        cnt_r  <= '0;
      end else if (beat_s) begin
        cnt_r  <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Valid bits: flush clears all, completed fill validates its set
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_r <= '0;
    end else if (iflush) begin
      valid_r <= '0;
    end else if (last_beat_s) begin
      valid_r[midx_r] <= 1'b1;
    end
  end

  // Tag and data storage are not reset; valid bits guard their contents
  always_ff @(posedge CLK) begin
    if (beat_s && !iflush) begin
      data_r[midx_r][cnt_r] <= iload;
    end
    if (last_beat_s && !iflush) begin
      tag_r[midx_r] <= mtag_r;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;

  // Saturating hit/miss statistics, untouched by flush
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_r  <= 32'h0000_0000;
      miss_cnt_r <= 32'h0000_0000;
    end else begin
      if (hit_s && (hit_cnt_r != 32'hFFFF_FFFF)) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (start_fill_s && (miss_cnt_r != 32'hFFFF_FFFF)) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_icache_param.sv
// Directed bench for icache_param (SETS=16, BLK_WORDS=2): table of fetches plus flush/reset sequences.
module tb_icache_param;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  icache_param #(.SETS(16), .BLK_WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC3A5_5A3C;
  endfunction

  assign iload = mem_word(iaddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one fetch and follow it through any refill until it hits.
  task automatic fetch(input logic [31:0] addr, input int waits, input bit miss);
    int lat;
    int beat;
    int wcnt;
    logic [31:0] base;
    base = addr & 32'hFFFF_FFF8;
    lat = 0; beat = 0; wcnt = 0;
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = addr; iflush = 1'b0; iwait = (waits > 0); #1;
    chk("first_cycle_hit", 32'(ihit), 32'(!miss));
    while (!ihit && lat < 60) begin
      if (iREN) begin
        chk("fill_iaddr", iaddr, base + 32'(beat * 4));
        if (iwait) wcnt++;
        else begin beat++; wcnt = 0; end
      end
      @(negedge CLK);
      iwait = (wcnt < waits); #1;
      lat++;
    end
    chk("hit", 32'(ihit), 32'd1);
    chk("imemload", imemload, mem_word(addr));
    chk("iren_on_hit", 32'(iREN), 32'd0);
    if (miss) begin
      chk("miss_latency", 32'(lat), 32'(2 * (waits + 1) + 1));
      chk("beats", 32'(beat), 32'd2);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          waits;
    bit          miss;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h0000_0040, 0, 1'b1};
    vecs[1] = '{32'h0000_0044, 0, 1'b0};
    vecs[2] = '{32'h0000_0440, 0, 1'b1};
    vecs[3] = '{32'h0000_0040, 0, 1'b1};
    vecs[4] = '{32'h0000_0080, 3, 1'b1};
    vecs[5] = '{32'h0000_0084, 0, 1'b0};
    vecs[6] = '{32'h0000_0044, 0, 1'b0};

    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0000_0040; iflush = 1'b0; iwait = 1'b0;
    #12;
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 32'h0);
    chk("rst_miss_cnt", miss_cnt, 32'h0);
`endif
    @(negedge CLK); nRST = 1'b1; imemREN = 1'b0;

    for (int i = 0; i < 7; i++) begin
      fetch(vecs[i].addr, vecs[i].waits, vecs[i].miss);
`ifdef ICACHE_STATS_EN
      if (i == 3) begin
        @(negedge CLK); imemREN = 1'b0; #1;
        chk("stat_miss_cnt", miss_cnt, 32'd3);
        chk("stat_hit_cnt", hit_cnt, 32'd4);
        force dut.hit_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt_r;
        fetch(32'h0000_0040, 0, 1'b0);
        @(negedge CLK); @(negedge CLK); imemREN = 1'b0; #1;
        chk("hit_cnt_saturate", hit_cnt, 32'hFFFF_FFFF);
      end
`endif
    end

    // Flush during the second beat of a fill.
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h0000_0200; iwait = 1'b0; #1;
    chk("fl_miss", 32'(ihit), 32'd0);
    @(negedge CLK); #1;
    chk("fl_beat0_iaddr", iaddr, 32'h0000_0200);
    @(negedge CLK); iflush = 1'b1; #1;
    chk("fl_beat1_iren", 32'(iREN), 32'd1);
    @(negedge CLK); iflush = 1'b0; imemREN = 1'b0; #1;
    chk("fl_iren_drop", 32'(iREN), 32'd0);
    fetch(32'h0000_0200, 0, 1'b1);
    fetch(32'h0000_0044, 0, 1'b1);

    // Flush while idle: hit suppressed in that cycle, lines gone afterwards.
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h0000_0044; iflush = 1'b1; #1;
    chk("idle_flush_ihit", 32'(ihit), 32'd0);
    @(negedge CLK); iflush = 1'b0; imemREN = 1'b0; #1;
    fetch(32'h0000_0200, 0, 1'b1);
    fetch(32'h0000_0044, 0, 1'b1);

    // Request dropped and address changed during a fill.
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h0000_0300; #1;
    chk("chg_miss", 32'(ihit), 32'd0);
    @(negedge CLK); imemREN = 1'b0; imemaddr = 32'h0000_0044; #1;
    chk("chg_iren", 32'(iREN), 32'd1);
    chk("chg_iaddr0", iaddr, 32'h0000_0300);
    @(negedge CLK); #1;
    chk("chg_iaddr1", iaddr, 32'h0000_0304);
    @(negedge CLK); #1;
    chk("chg_done", 32'(iREN), 32'd0);
    fetch(32'h0000_0304, 0, 1'b0);
    fetch(32'h0000_0044, 0, 1'b0);

    // Asynchronous reset in the middle of a fill.
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h0000_0400; #1;
    @(negedge CLK); #1;
    chk("ar_iren_before", 32'(iREN), 32'd1);
    #1 nRST = 1'b0; imemREN = 1'b0; #1;
    chk("ar_iren_now", 32'(iREN), 32'd0);
    chk("ar_iaddr_now", iaddr, 32'h0);
    @(negedge CLK); nRST = 1'b1;
    fetch(32'h0000_0044, 0, 1'b1);

    @(negedge CLK); imemREN = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
